quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder.sv | 145 ++++++++++++++
 tb/tb_quad_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// ============================================================================
// quad_decoder : x4 quadrature decoder with synchronizers, glitch filter, index
// Rev 1.0
// ============================================================================
`default_nettype none

module quad_decoder #(
    parameter int N    = 16,
    parameter int FILT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a,
    input  logic         b,
    input  logic         idx,
    input  logic         clr,
    input  logic         err_clr,
    output logic [N-1:0] pos,
    output logic         dir,
    output logic         step,
    output logic         err
);

    localparam int CW = 4;
    localparam int PW = 5;
    localparam logic [CW-1:0] FILT_LAST  = CW'(FILT - 1);
    localparam logic [PW-1:0] PRIME_LAST = PW'(FILT + 1);

    // channel 0 = A, 1 = B, 2 = index
    logic [2:0]         sync1;
    logic [2:0]         sync2;
    logic [2:0]         filt;
    logic [2:0]         filt_nxt;
    logic [2:0][CW-1:0] cnt;
    logic [2:0][CW-1:0] cnt_nxt;

    logic [PW-1:0] prime_cnt;
    logic          primed;
    logic [1:0]    prev_ab;
    logic          prev_idx;

    logic [1:0]    cur_ab;
    logic [1:0]    chg;
    logic          legal;
    logic          illegal;
    logic          up;
    logic          idx_rise;

    logic [N-1:0]  pos_nxt;
    logic          dir_nxt;
    logic          step_nxt;
    logic          err_nxt;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            filt_nxt[i] = filt[i];
            cnt_nxt[i]  = '0;
            if (sync2[i] != filt[i]) begin
                if (cnt[i] == FILT_LAST)
                    filt_nxt[i] = sync2[i];
                else
                    cnt_nxt[i] = cnt[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= {idx, b, a};
            sync2 <= sync1;
            filt  <= filt_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign cur_ab   = {filt[0], filt[1]};
    assign chg      = cur_ab ^ prev_ab;
    assign legal    = primed & (chg[0] ^ chg[1]);
    assign illegal  = primed & chg[0] & chg[1];
    // Gray-code direction: previous B xor new A is 1 for every up transition
    assign up       = prev_ab[0] ^ cur_ab[1];
    assign idx_rise = primed & filt[2] & ~prev_idx;

    // Priming adopts the filter's next value so a level settling on the
    // priming edge itself becomes the reference state without counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prime_cnt <= '0;
            primed    <= 1'b0;
            prev_ab   <= 2'b00;
            prev_idx  <= 1'b0;
        end else if (!primed) begin
            if (prime_cnt == PRIME_LAST) begin
                primed   <= 1'b1;
                prev_ab  <= {filt_nxt[0], filt_nxt[1]};
                prev_idx <= filt_nxt[2];
            end else begin
                prime_cnt <= prime_cnt + PW'(1);
            end
        end else begin
            prev_ab  <= cur_ab;
            prev_idx <= filt[2];
        end
    end

    always_comb begin
        pos_nxt  = pos;
        dir_nxt  = dir;
        step_nxt = 1'b0;
        err_nxt  = err;
        if (clr || idx_rise) begin
            pos_nxt = '0;
        end else if (legal) begin
            pos_nxt  = up ? pos + N'(1) : pos - N'(1);
            dir_nxt  = up;
            step_nxt = 1'b1;
        end
        if (illegal)
            err_nxt = 1'b1;
        else if (err_clr)
            err_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos  <= '0;
            dir  <= 1'b0;
            step <= 1'b0;
            err  <= 1'b0;
        end else begin
            pos  <= pos_nxt;
            dir  <= dir_nxt;
            step <= step_nxt;
            err  <= err_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_quad_decoder.sv
// ============================================================================
// tb_quad_decoder : scoreboard bench for quad_decoder (N=16, FILT=3)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_quad_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a = 1'b0;
    logic        b = 1'b0;
    logic        idx = 1'b0;
    logic        clr = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] pos;
    logic        dir;
    logic        step;
    logic        err;

    int tests = 0;
    int fails = 0;

    logic [16:0] sb [$];
    logic [15:0] mpos = 16'h0;
    logic [1:0]  st = 2'b00;

    quad_decoder #(.N(16), .FILT(3)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .idx(idx), .clr(clr),
        .err_clr(err_clr), .pos(pos), .dir(dir), .step(step), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every step pulse must match the oldest expected entry
    always @(posedge clk) begin
        #1;
        if (!rst && step) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_step: pos=0x%0h dir=%0d, none expected", pos, dir);
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                if ({pos, dir} !== e) begin
                    fails++;
                    $display("FAIL step_value: got pos=0x%0h dir=%0d expected pos=0x%0h dir=%0d",
                             pos, dir, e[16:1], e[0]);
                end
            end
        end
    end

    function automatic logic [1:0] up_of(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] down_of(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Drive new pin levels at a falling edge and measure the step latency
    task automatic apply(input logic [1:0] s, input bit exp_step);
        int lat;
        lat = 0;
        @(negedge clk);
        a = s[1];
        b = s[0];
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (step && lat == 0) lat = k;
        end
        if (exp_step) check("step_latency", lat, 6);
    endtask

    task automatic step_up();
        mpos = mpos + 16'h1;
        sb.push_back({mpos, 1'b1});
        st = up_of(st);
        apply(st, 1'b1);
    endtask

    task automatic step_down();
        mpos = mpos - 16'h1;
        sb.push_back({mpos, 1'b0});
        st = down_of(st);
        apply(st, 1'b1);
    endtask

    task automatic do_reset(input logic [1:0] s);
        @(negedge clk);
        a = s[1];
        b = s[0];
        rst = 1'b1;
        #1;
        check("reset_pos", pos, 0);
        check("reset_flags", {dir, step, err}, 0);
        @(negedge clk);
        rst = 1'b0;
        st = s;
        mpos = 16'h0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Release with 11 held: priming adopts it silently
        do_reset(2'b11);
        check("prime11_pos", pos, 0);
        check("prime11_err", err, 0);

        // Four up steps from 00
        do_reset(2'b00);
        for (int i = 0; i < 4; i++) step_up();
        check("up4_pos", pos, 4);
        check("up4_dir", dir, 1);

        // Wrap-around below zero and back
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        mpos = 16'h0;
        check("clr_pos", pos, 0);
        check("clr_keeps_dir", dir, 1);
        step_down();
        check("wrap_down_pos", pos, 16'hFFFF);
        check("wrap_down_dir", dir, 0);
        step_up();
        check("wrap_up_pos", pos, 0);

        // Two-cycle glitch on A is filtered out
        @(negedge clk); a = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk); a = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("glitch_pos", pos, 0);
        check("glitch_err", err, 0);

        // Illegal 00 -> 11
        apply(2'b11, 1'b0);
        st = 2'b11;
        check("illegal_err", err, 1);
        check("illegal_pos", pos, 0);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("err_clr", err, 0);

        // err_clr coincident with a new illegal transition: set wins
        @(negedge clk);
        a = 1'b0;
        b = 1'b0;
        st = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        check("pre_illegal2_err", err, 0);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("illegal_setwins_err", err, 1);
        check("illegal2_pos", pos, 0);

        // Count up to 0x0123
        for (int i = 0; i < 16'h0123; i++) step_up();
        check("count_0123", pos, 16'h0123);

        // Index rise together with an up step: load zero, no step
        st = up_of(st);
        @(negedge clk);
        a = st[1];
        b = st[0];
        idx = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        mpos = 16'h0;
        check("idx_pos", pos, 0);

        // clr on the same edge as a step
        check("pre_clr_step_pos", pos, 0);
        step_up();
        check("pos_before_clr", pos, 1);
        st = up_of(st);
        @(negedge clk);
        a = st[1];
        b = st[0];
        repeat (5) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_with_step_pos", pos, 0);

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
